// File: rtl/ds_pkg.sv
// Shared 1-wire DS18B20 definitions: receiver states, Dallas CRC-8 and ROM/function commands.
package ds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ds_state_t;

    localparam int unsigned CRC_W      = 8;
    localparam int unsigned FRAME_BITS = 72;

    localparam logic [CRC_W-1:0] CRC_POLY = 8'h8C;

    localparam logic [7:0] CMD_SKIP_ROM      = 8'hCC;
    localparam logic [7:0] CMD_CONVERT_T     = 8'h44;
    localparam logic [7:0] CMD_READ_SCRATCH  = 8'hBE;

    // One LSB-first step of the reflected Dallas/Maxim CRC-8.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc, input logic b);
        logic             fb;
        logic [CRC_W-1:0] n;
        fb = crc[0] ^ b;
        n  = crc >> 1;
        if (fb) begin
            n = n ^ CRC_POLY;
        end
        return n;
    endfunction

endpackage

// File: rtl/ds_crc8.sv
// Serial CRC-8 accumulator; clear has priority over enable.
module ds_crc8
    import ds_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/ds_scratchpad_rx.sv
// Collects a 1-wire read-scratchpad frame bit by bit, checks its CRC and
// publishes the decoded temperature and resolution.
module ds_scratchpad_rx
    import ds_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FRAME_BITS / 8,
    parameter int unsigned TEMP_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic              done,
    output logic              temp_valid,
    output logic              crc_err,
    output logic              dev_absent,
    output logic [TEMP_W-1:0] temp_raw,
    output logic [7:0]        temp_c,
    output logic [1:0]        res_cfg
);

    localparam int unsigned NBITS   = FRAME_BYTES * 8;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned RES_LSB = 4 * 8 + 5;

    ds_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NBITS-2:0]   shreg_q, shreg_d;
    logic [NBITS-1:0]   shift_next;
    logic [CRC_W-1:0]   crc_q, crc_next;
    logic               crc_clr, crc_en;

    logic               busy_d, done_d, temp_valid_d, crc_err_d, dev_absent_d;
    logic [TEMP_W-1:0]  temp_raw_d;
    logic [7:0]         temp_c_d;
    logic [1:0]         res_cfg_d;

    logic [TEMP_W-1:0]        frame_temp;
    logic signed [TEMP_W-1:0] frame_asr;

    ds_crc8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (bit_in),
        .crc    (crc_q)
    );

    // Frame and CRC as they will look once the current bit is taken, so the
    // verdict can be registered on the same edge that accepts the last bit.
    assign shift_next = {bit_in, shreg_q};
    assign crc_next   = crc8_step(crc_q, bit_in);
    assign frame_temp = TEMP_W'($signed(shift_next[15:0]));
    assign frame_asr  = $signed(frame_temp) >>> 4;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        temp_valid_d = 1'b0;
        crc_err_d    = 1'b0;
        dev_absent_d = 1'b0;
        temp_raw_d   = temp_raw;
        temp_c_d     = temp_c;
        res_cfg_d    = res_cfg;

        // start restarts from any state and swallows a coincident bit
        if (start) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            shreg_d = '0;
            crc_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (bit_valid) begin
                        crc_en  = 1'b1;
                        shreg_d = shift_next[NBITS-1:1];
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(NBITS - 1)) begin
                            state_d = ST_CHECK;
                            done_d  = 1'b1;
                            if (&shift_next) begin
                                dev_absent_d = 1'b1;
                            end else if (crc_next == '0) begin
                                temp_valid_d = 1'b1;
                                temp_raw_d   = frame_temp;
                                temp_c_d     = frame_asr[7:0];
                                res_cfg_d    = shift_next[RES_LSB+1:RES_LSB];
                            end else begin
                                crc_err_d = 1'b1;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            temp_valid <= 1'b0;
            crc_err    <= 1'b0;
            dev_absent <= 1'b0;
            temp_raw   <= '0;
            temp_c     <= '0;
            res_cfg    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            busy       <= busy_d;
            done       <= done_d;
            temp_valid <= temp_valid_d;
            crc_err    <= crc_err_d;
            dev_absent <= dev_absent_d;
            temp_raw   <= temp_raw_d;
            temp_c     <= temp_c_d;
            res_cfg    <= res_cfg_d;
        end
    end

endmodule

// File: tb/tb_ds_scratchpad_rx.sv
// Directed frame table plus restart/reset/idle-noise sequences for ds_scratchpad_rx.
module tb_ds_scratchpad_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bit_valid;
    logic        bit_in;
    logic        busy;
    logic        done;
    logic        temp_valid;
    logic        crc_err;
    logic        dev_absent;
    logic [15:0] temp_raw;
    logic [7:0]  temp_c;
    logic [1:0]  res_cfg;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    ds_scratchpad_rx #(.FRAME_BYTES(9), .TEMP_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .busy       (busy),
        .done       (done),
        .temp_valid (temp_valid),
        .crc_err    (crc_err),
        .dev_absent (dev_absent),
        .temp_raw   (temp_raw),
        .temp_c     (temp_c),
        .res_cfg    (res_cfg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [71:0] frame;
        logic        gap;
        logic        tv;
        logic        ce;
        logic        da;
        logic [15:0] raw;
        logic [7:0]  tc;
        logic [1:0]  res;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_of(input logic [63:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bits(input logic [71:0] f, input int first, input int last, input logic gap);
        for (int i = first; i <= last; i++) begin
            bit_valid = 1'b1;
            bit_in    = f[i];
            tick();
            bit_valid = 1'b0;
            if (gap && i != last) tick();
        end
    endtask

    task automatic check_result(input string nm, input logic tv, input logic ce, input logic da,
                                input logic [15:0] raw, input logic [7:0] tc, input logic [1:0] res);
        chk({nm, ".done"},       32'(done),       32'(1'b1));
        chk({nm, ".busy"},       32'(busy),       32'(1'b1));
        chk({nm, ".temp_valid"}, 32'(temp_valid), 32'(tv));
        chk({nm, ".crc_err"},    32'(crc_err),    32'(ce));
        chk({nm, ".dev_absent"}, 32'(dev_absent), 32'(da));
        chk({nm, ".temp_raw"},   32'(temp_raw),   32'(raw));
        chk({nm, ".temp_c"},     32'(temp_c),     32'(tc));
        chk({nm, ".res_cfg"},    32'(res_cfg),    32'(res));
        tick();
        chk({nm, ".done_low"},   32'(done),       32'(1'b0));
        chk({nm, ".busy_low"},   32'(busy),       32'(1'b0));
        chk({nm, ".flags_low"},  32'({temp_valid, crc_err, dev_absent}), 32'(3'b000));
        chk({nm, ".raw_hold"},   32'(temp_raw),   32'(raw));
    endtask

    initial begin
        logic [71:0] f85;
        logic [63:0] neg_body;
        logic [63:0] p25_body;
        int          d0;

        f85      = {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};
        neg_body = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'hFF, 8'h5E};
        p25_body = {8'h10, 8'h0C, 8'hFF, 8'h1F, 8'h46, 8'h4B, 8'h01, 8'h91};

        vecs[0] = '{"good85",   f85,                            1'b0, 1'b1, 1'b0, 1'b0, 16'h0550, 8'h55, 2'b11};
        vecs[1] = '{"badcrc",   {8'h1D, f85[63:0]},             1'b1, 1'b0, 1'b1, 1'b0, 16'h0550, 8'h55, 2'b11};
        vecs[2] = '{"absent",   {72{1'b1}},                     1'b0, 1'b0, 1'b0, 1'b1, 16'h0550, 8'h55, 2'b11};
        vecs[3] = '{"neg11",    {crc_of(neg_body), neg_body},   1'b1, 1'b1, 1'b0, 1'b0, 16'hFF5E, 8'hF5, 2'b11};
        vecs[4] = '{"pos25",    {crc_of(p25_body), p25_body},   1'b0, 1'b1, 1'b0, 1'b0, 16'h0191, 8'h19, 2'b00};
        vecs[5] = '{"zeros",    72'h0,                          1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00};
        vecs[6] = '{"zerobad",  {8'h01, 64'h0},                 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 2'b00};

        rst       = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (2) tick();
        chk("reset.busy",    32'(busy),     32'(1'b0));
        chk("reset.flags",   32'({done, temp_valid, crc_err, dev_absent}), 32'(4'b0000));
        chk("reset.outputs", 32'({temp_raw, temp_c, res_cfg}), 32'(26'h0));
        rst = 1'b1;
        tick();

        // Table of complete frames, each judged one cycle after its last bit
        for (int v = 0; v < 7; v++) begin
            d0 = done_cnt;
            pulse_start();
            chk({vecs[v].name, ".busy_start"}, 32'(busy), 32'(1'b1));
            send_bits(vecs[v].frame, 0, 71, vecs[v].gap);
            check_result(vecs[v].name, vecs[v].tv, vecs[v].ce, vecs[v].da,
                         vecs[v].raw, vecs[v].tc, vecs[v].res);
            chk({vecs[v].name, ".done_count"}, 32'(done_cnt - d0), 32'd1);
        end

        // Restart after 40 bits, with start colliding with a bit strobe
        d0 = done_cnt;
        pulse_start();
        send_bits(f85, 0, 39, 1'b0);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        chk("restart.busy", 32'(busy), 32'(1'b1));
        send_bits(f85, 0, 71, 1'b0);
        check_result("restart", 1'b1, 1'b0, 1'b0, 16'h0550, 8'h55, 2'b11);
        chk("restart.done_count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset mid-frame, then a clean negative frame
        d0 = done_cnt;
        pulse_start();
        send_bits(vecs[3].frame, 0, 29, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.busy",    32'(busy), 32'(1'b0));
        chk("midrst.flags",   32'({done, temp_valid, crc_err, dev_absent}), 32'(4'b0000));
        chk("midrst.outputs", 32'({temp_raw, temp_c, res_cfg}), 32'(26'h0));
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst.no_done", 32'(done_cnt - d0), 32'd0);
        pulse_start();
        send_bits(vecs[3].frame, 0, 71, 1'b1);
        check_result("afterrst", 1'b1, 1'b0, 1'b0, 16'hFF5E, 8'hF5, 2'b11);
        chk("afterrst.done_count", 32'(done_cnt - d0), 32'd1);

        // Bit strobes while idle must not land in the next frame
        d0 = done_cnt;
        send_bits({72{1'b1}}, 0, 4, 1'b1);
        chk("idlebits.busy",    32'(busy), 32'(1'b0));
        chk("idlebits.no_done", 32'(done_cnt - d0), 32'd0);
        pulse_start();
        send_bits(f85, 0, 71, 1'b0);
        check_result("idlebits", 1'b1, 1'b0, 1'b0, 16'h0550, 8'h55, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
